// File: rtl/stack_alu_sequencer_if.sv
// Command/response channel between the CPU control path and the stack ALU sequencer.
// master = command initiator (CPU side), slave = sequencer.
interface stack_alu_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_kind;
   logic [4:0]  cmd_opcode;
   logic [15:0] cmd_data;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic [1:0]  rsp_err;

   modport master (
      output cmd_valid, cmd_kind, cmd_opcode, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_kind, cmd_opcode, cmd_data,
      output cmd_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/stack_alu_sequencer.sv
// Operand-stack front end for the combinational 16-bit ALU: PUSH/POP/ALU commands,
// ALU ops pop b then a, execute, and push the result back with a one-cycle response.
module stack_alu_sequencer #(
   parameter  int DEPTH = 16,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   stack_alu_sequencer_if.slave bus,
   output logic [4:0]           alu_opcode,
   output logic [15:0]          alu_a,
   output logic [15:0]          alu_b,
   input  logic [15:0]          alu_out,
   output logic [CW-1:0]        depth,
   output logic [15:0]          top
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_POP_B, S_POP_A, S_EXEC, S_WB} state_t;
   typedef enum logic [1:0] {K_NOP, K_PUSH, K_POP, K_ALU} kind_t;

   state_t        state, state_nxt;
   kind_t         kind;
   logic [15:0]   mem [DEPTH];
   logic [4:0]    op_q;
   logic [15:0]   result_q;
   logic          full, empty, accept;
   logic          wr_en;
   logic [15:0]   wr_data;
   logic [AW-1:0] wr_idx, top_idx;

   assign kind          = kind_t'(bus.cmd_kind);
   assign bus.cmd_ready = (state == S_IDLE);
   assign accept        = bus.cmd_valid && (state == S_IDLE);
   assign full          = (depth == CW'(DEPTH));
   assign empty         = (depth == '0);
   // Modulo indexing: depth == DEPTH wraps to 0, so top_idx still lands on DEPTH-1.
   assign wr_idx        = depth[AW-1:0];
   assign top_idx       = depth[AW-1:0] - AW'(1);
   assign top           = empty ? '0 : mem[top_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      wr_data   = bus.cmd_data;
      case (state)
         S_IDLE: begin
            if (accept) begin
               case (kind)
                  K_PUSH:  wr_en = !full;
                  K_ALU:   if (depth >= CW'(2)) state_nxt = S_POP_B;
                  default: ;
               endcase
            end
         end
         S_POP_B: state_nxt = S_POP_A;
         S_POP_A: state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_WB;
         S_WB: begin
            state_nxt = S_IDLE;
            wr_en     = 1'b1;
            wr_data   = result_q;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Stack storage carries no reset; occupancy alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         depth         <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_err   <= '0;
         alu_opcode    <= '0;
         alu_a         <= '0;
         alu_b         <= '0;
         op_q          <= '0;
         result_q      <= '0;
      end else begin
         bus.rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q <= bus.cmd_opcode;
                  case (kind)
                     K_PUSH: begin
                        bus.rsp_valid <= 1'b1;
                        if (!full) begin
                           depth        <= depth + CW'(1);
                           bus.rsp_data <= bus.cmd_data;
                           bus.rsp_err  <= 2'b00;
                        end else begin
                           bus.rsp_data <= '0;
                           bus.rsp_err  <= 2'b10;
                        end
                     end
                     K_POP: begin
                        bus.rsp_valid <= 1'b1;
                        if (!empty) begin
                           depth        <= depth - CW'(1);
                           bus.rsp_data <= top;
                           bus.rsp_err  <= 2'b00;
                        end else begin
                           bus.rsp_data <= '0;
                           bus.rsp_err  <= 2'b01;
                        end
                     end
                     K_ALU: begin
                        if (depth < CW'(2)) begin
                           bus.rsp_valid <= 1'b1;
                           bus.rsp_data  <= '0;
                           bus.rsp_err   <= 2'b01;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_POP_B: begin
               alu_b      <= mem[top_idx];
               alu_opcode <= op_q;
               depth      <= depth - CW'(1);
            end
            S_POP_A: begin
               alu_a <= mem[top_idx];
               depth <= depth - CW'(1);
            end
            S_EXEC: result_q <= alu_out;
            S_WB: begin
               depth         <= depth + CW'(1);
               bus.rsp_valid <= 1'b1;
               bus.rsp_data  <= result_q;
               bus.rsp_err   <= 2'b00;
            end
            default: ;
         endcase
      end
   end

endmodule
